// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and state type for the seven-segment scan controller
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [7:0]  ALNUM_MAX  = 8'd35;

  localparam logic [7:0] CODE_0     = 8'd0;
  localparam logic [7:0] CODE_1     = 8'd1;
  localparam logic [7:0] CODE_2     = 8'd2;
  localparam logic [7:0] CODE_3     = 8'd3;
  localparam logic [7:0] CODE_4     = 8'd4;
  localparam logic [7:0] CODE_5     = 8'd5;
  localparam logic [7:0] CODE_6     = 8'd6;
  localparam logic [7:0] CODE_7     = 8'd7;
  localparam logic [7:0] CODE_8     = 8'd8;
  localparam logic [7:0] CODE_9     = 8'd9;
  localparam logic [7:0] CODE_A     = 8'd10;
  localparam logic [7:0] CODE_B     = 8'd11;
  localparam logic [7:0] CODE_C     = 8'd12;
  localparam logic [7:0] CODE_D     = 8'd13;
  localparam logic [7:0] CODE_E     = 8'd14;
  localparam logic [7:0] CODE_F     = 8'd15;
  localparam logic [7:0] CODE_BLANK = 8'd36;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_digit_buffer.sv
// rtl/seg_digit_buffer.sv - 8x8 digit code register file, one write port, async read
module seg_digit_buffer
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem_q [NUM_DIGITS];
  logic [7:0] mem_d [NUM_DIGITS];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the pre-write contents, so a same-edge write is never latched.
  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 8-digit scan with dead-time blanking
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] show_mask,
  input  logic [7:0] dp_mask,
  output logic [7:0] alnum,
  output logic       dp_n,
  output logic [7:0] an_n,
  output logic [2:0] scan_idx,
  output logic       frame_tick
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST   = CW'(SCAN_DIV - DEAD_CYCLES - 1);

  if (DEAD_CYCLES == 0 || DEAD_CYCLES >= SCAN_DIV || SCAN_DIV < 2 || SCAN_DIV > (1 << 20))
  begin : g_bad_params
    $fatal(1, "seg_scan_ctrl: illegal SCAN_DIV/DEAD_CYCLES combination");
  end

  scan_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    scan_idx_q, scan_idx_d;
  logic [7:0]    alnum_q, alnum_d;
  logic          frame_tick_q, frame_tick_d;
  logic [2:0]    nxt_idx;
  logic [7:0]    rd_data;
  logic          visible;

  assign nxt_idx = scan_idx_q + 3'd1;

  seg_digit_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (nxt_idx),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    scan_idx_d   = scan_idx_q;
    alnum_d      = alnum_q;
    frame_tick_d = 1'b0;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == DEAD_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
        end
      end
      S_ON: begin
        // Next code is latched on entry to dead time so the decoder settles while dark.
        if (cnt_q == ON_LAST) begin
          state_d      = S_BLANK;
          cnt_d        = '0;
          scan_idx_d   = nxt_idx;
          alnum_d      = rd_data;
          frame_tick_d = (scan_idx_q == 3'd7);
        end
      end
      default: begin
        state_d = S_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BLANK;
      cnt_q        <= '0;
      scan_idx_q   <= 3'd0;
      alnum_q      <= 8'd0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_idx_q   <= scan_idx_d;
      alnum_q      <= alnum_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Undefined codes light every segment in the decoder, so they are blanked here.
  assign visible = show_mask[scan_idx_q] && (alnum_q <= ALNUM_MAX);

  always_comb begin
    an_n = 8'hFF;
    dp_n = 1'b1;
    if (state_q == S_ON && visible) begin
      an_n[scan_idx_q] = 1'b0;
      dp_n             = ~dp_mask[scan_idx_q];
    end
  end

  assign alnum      = alnum_q;
  assign scan_idx   = scan_idx_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl with a slot-arithmetic model
module tb_seg_scan_ctrl;

  localparam int SD = 8;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] show_mask = 8'hFF;
  logic [7:0] dp_mask = 8'h00;
  logic [7:0] alnum;
  logic       dp_n;
  logic [7:0] an_n;
  logic [2:0] scan_idx;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  // Model: time since reset release, current buffer, and code latched for this slot.
  int         t;
  logic [7:0] mbuf [8];
  logic [7:0] lat;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.SCAN_DIV(SD), .DEAD_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .show_mask  (show_mask),
    .dp_mask    (dp_mask),
    .alnum      (alnum),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .scan_idx   (scan_idx),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t   = 0;
    lat = 8'd0;
    for (int i = 0; i < 8; i++) mbuf[i] = 8'd0;
  endtask

  task automatic check_outputs();
    int         d;
    bit         on;
    bit         vis;
    logic [7:0] exp_an;
    logic       exp_dp;
    d      = (t / SD) % 8;
    on     = (t % SD) >= DC;
    vis    = show_mask[d] && (lat <= 8'd35);
    exp_an = (on && vis) ? ~(8'd1 << d) : 8'hFF;
    exp_dp = !(on && vis && dp_mask[d]);
    check("an_n", {24'd0, an_n}, {24'd0, exp_an});
    check("dp_n", {31'd0, dp_n}, {31'd0, exp_dp});
    check("alnum", {24'd0, alnum}, {24'd0, lat});
    check("scan_idx", {29'd0, scan_idx}, d);
    check("frame_tick", {31'd0, frame_tick}, {31'd0, (t > 0) && (t % (8 * SD) == 0)});
  endtask

  task automatic tick(input logic we, input logic [2:0] wa, input logic [7:0] wd);
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    @(posedge clk);
    if (((t + 1) % SD) == 0) lat = mbuf[((t + 1) / SD) % 8];
    if (we) mbuf[wa] = wd;
    t++;
    @(negedge clk);
    wr_en = 1'b0;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 8'd0);
  endtask

  initial begin
    int nd;
    model_reset();

    // Reset state
    #12;
    check("rst_an_n", {24'd0, an_n}, 32'hFF);
    check("rst_alnum", {24'd0, alnum}, 32'h0);
    check("rst_dp_n", {31'd0, dp_n}, 32'h1);
    check("rst_scan_idx", {29'd0, scan_idx}, 32'h0);
    check("rst_frame_tick", {31'd0, frame_tick}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();

    // Basic scan with empty buffer, past the first frame wrap
    run(80);

    // Codes 1..8 into digits 0..7, then two full frames
    for (int i = 0; i < 8; i++) tick(1'b1, 3'(i), 8'(i + 1));
    run(128);

    // Masked digits and an out-of-range code on digit 5
    show_mask = 8'h0F;
    tick(1'b1, 3'd5, 8'd40);
    run(64);
    show_mask = 8'hFF;
    run(64);

    // Decimal point on digit 2 only
    dp_mask = 8'h04;
    run(64);
    dp_mask = 8'h00;

    // Write the digit being latched on the same edge
    for (int i = 0; i < SD && ((t + 1) % SD) != 0; i++) tick(1'b0, 3'd0, 8'd0);
    nd = ((t + 1) / SD) % 8;
    tick(1'b1, 3'(nd), 8'd20);
    run(128);

    // Mid-slot write to digit 3 while it is lit
    for (int i = 0; i < 8 * SD && !(((t / SD) % 8) == 3 && (t % SD) >= DC); i++)
      tick(1'b0, 3'd0, 8'd0);
    tick(1'b1, 3'd3, 8'h0A);
    run(72);

    // Randomized writes and mask changes
    for (int i = 0; i < 640; i++) begin
      if ((i % 16) == 0) begin
        show_mask = 8'($urandom);
        dp_mask   = 8'($urandom);
      end
      if ($urandom_range(0, 3) == 0)
        tick(1'b1, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 45)));
      else
        tick(1'b0, 3'd0, 8'd0);
    end
    show_mask = 8'hFF;
    dp_mask   = 8'hFF;

    // Async reset while digit 6 is lit
    for (int i = 0; i < 8 * SD && !(((t / SD) % 8) == 6 && (t % SD) >= DC); i++)
      tick(1'b0, 3'd0, 8'd0);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_an_n", {24'd0, an_n}, 32'hFF);
    check("async_rst_alnum", {24'd0, alnum}, 32'h0);
    check("async_rst_dp_n", {31'd0, dp_n}, 32'h1);
    check("async_rst_scan_idx", {29'd0, scan_idx}, 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    run(72);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the 8-digit seven-segment display; sits directly upstream of the alnum-to-segment decoder. Holds an 8-entry buffer of 8-bit alnum codes (0-15 hex, 16-35 letters) written by the CPU/debug logic. Presents one code per slot to the decoder while driving the active-low digit anodes, with a dead-time blank between digits to suppress ghosting.

Parameters:
SCAN_DIV, 100000, clocks per digit slot (dead time plus on time); legal range 2..2^20.
DEAD_CYCLES, 1000, clocks per slot with all anodes off; legal range 1..SCAN_DIV-1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write strobe, one entry per cycle
wr_addr  in  3  digit index to write (0 = rightmost)
wr_data  in  8  alnum code
show_mask  in  8  bit i = 1 enables digit i
dp_mask  in  8  bit i = 1 lights decimal point of digit i
alnum  out  8  code for current digit, to decoder
dp_n  out  1  active-low decimal point, ANDed externally with decoder p
an_n  out  8  active-low anode enables
scan_idx  out  3  digit currently selected
frame_tick  out  1  one-cycle pulse when scan wraps 7->0

Behaviour:
- Reset values: buffer entries all 8'd0; alnum=8'd0; dp_n=1; an_n=8'hFF; scan_idx=0; frame_tick=0; state=S_BLANK; slot counter=0.
- State S_BLANK: an_n=8'hFF and dp_n=1. Lasts exactly DEAD_CYCLES clocks, then S_ON.
- State S_ON: an_n has only bit scan_idx low, and only if the digit is visible. Lasts exactly SCAN_DIV-DEAD_CYCLES clocks. On exit: scan_idx increments mod 8 and the state returns to S_BLANK.
- Slot period is SCAN_DIV clocks; frame period is 8*SCAN_DIV clocks.
- alnum and dp_n source values are latched once, on the clock edge entering S_BLANK: alnum = buffer[new scan_idx]. This gives the decoder the whole dead time to settle.
- dp_n is driven low only in S_ON and only when dp_mask[scan_idx]=1 and the digit is visible.
- A digit is visible when show_mask[scan_idx]=1 and the latched code is <= 35. Codes >= 36 are blanked by holding its anode high. The decoder maps undefined codes to all-segments-on, so blanking is never delegated to it.
- show_mask and dp_mask are sampled combinationally each cycle in S_ON. Changing them mid-slot takes effect on the next clock.
- frame_tick pulses high for the single cycle in which scan_idx changes from 7 to 0.
- Write: on a clk edge with wr_en=1, buffer[wr_addr] <= wr_data. The write is visible in alnum no earlier than the next slot entry (tear-free).
- Write to the digit being latched on the same edge: the old value is latched and the new value is shown one frame later. Buffer read is before write.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronously) and the buffer is cleared. After release, the scan restarts at digit 0 in S_BLANK.
- Illegal parameters (DEAD_CYCLES >= SCAN_DIV or DEAD_CYCLES = 0) are rejected by an elaboration-time check.
- Slot counter width is clog2(SCAN_DIV). It resets to 0 on every state transition.

Decomposition:
- Shared package seg_pkg:
  - NUM_DIGITS=8
  - ALNUM_MAX=35
  - named code constants (CODE_0..CODE_F, CODE_BLANK=8'd36)
  - state enum {S_BLANK, S_ON}
- One sub-module, seg_digit_buffer: 8x8 register file with one write port, one asynchronous read port, and async reset clear.
- The FSM and counters stay in seg_scan_ctrl.

Test Plan:
- Reset, SCAN_DIV=8, DEAD_CYCLES=2, show_mask=FF -> an_n=FF for 2 clocks; then an_n=FE for 6 clocks with alnum=0; then an_n=FF for 2 clocks and an_n=FD. frame_tick is high exactly once per 64 clocks, on the 7->0 transition.
- Write codes 1..8 to addresses 0..7, then run one frame -> alnum sequence 1,2,...,8, each latched at slot start. scan_idx matches the low anode each slot.
- show_mask=8'h0F, buffer[5]=8'd40 -> digits 4-7 never drive an_n low. Digit 5 stays blank even with show_mask=FF, because code 40 > 35.
- dp_mask=8'h04 -> dp_n=0 only during S_ON of digit 2. dp_n=1 during all dead time.
- While digit 3 is in S_ON, write buffer[3]=8'hA -> alnum does not change mid-slot. The new value appears at digit 3's next slot entry.
- Assert rst during S_ON of digit 6 -> an_n=FF and alnum=0 in the same cycle. After release, digit 0 is shown first with buffer contents zero.
